// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a small return-address stack.
// A run starts at address 0 on req, steps/jumps/calls/returns while in RUN,
// and ends when the PC reaches DONE_ADDR or the stack over/underflows.
module pc_sequencer #(
  parameter int D         = 12,
  parameter int S         = 4,
  parameter int DONE_ADDR = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   stall,
  input  logic                   reljump_en,
  input  logic                   absjump_en,
  input  logic                   call_en,
  input  logic                   ret_en,
  input  logic [D-1:0]           target,
  output logic [D-1:0]           prog_ctr,
  output logic                   running,
  output logic                   done,
  output logic                   stk_err,
  output logic [$clog2(S+1)-1:0] stk_depth
);

  localparam int DW = $clog2(S + 1);
  localparam int AW = (S > 1) ? $clog2(S) : 1;
  localparam logic [D-1:0]  PC_ONE    = D'(1);
  localparam logic [D-1:0]  PC_DONE   = D'(DONE_ADDR);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(S);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
  localparam logic [AW-1:0] IDX_ONE   = AW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t         r_state;
  logic [D-1:0]   r_pc;
  logic [DW-1:0]  r_depth;
  logic           r_err;
  logic           r_running;
  logic           r_done;
  logic [D-1:0]   r_stack [S];

  logic [D-1:0]   w_pc_inc;
  logic [D-1:0]   w_pc_rel;
  logic           w_at_done;
  logic           w_full;
  logic           w_empty;
  logic [AW-1:0]  w_push_idx;
  logic [AW-1:0]  w_pop_idx;
  logic           w_do_push;

  // Address arithmetic wraps naturally in D bits.
  assign w_pc_inc   = r_pc + PC_ONE;
  assign w_pc_rel   = r_pc + target;
  assign w_at_done  = (r_pc == PC_DONE);
  assign w_full     = (r_depth == DEPTH_MAX);
  assign w_empty    = (r_depth == '0);
  // Pop index is derived from the push index so a full stack (depth == S,
  // which truncates to a wrapped push index) still addresses the top entry.
  assign w_push_idx = r_depth[AW-1:0];
  assign w_pop_idx  = w_push_idx - IDX_ONE;
  assign w_do_push  = (r_state == ST_RUN) && !w_at_done && !stall &&
                      !ret_en && call_en && !w_full;

  // Sequencer FSM: state, PC, stack pointer, error flag and status outputs.
  // NOTE: every assignment in a clocked block is non-blocking so all flops
  // sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= '0;
      r_depth   <= '0;
      r_err     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pc    <= '0;
          r_depth <= '0;
          r_err   <= 1'b0;
          if (req) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_at_done) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (!stall) begin
            if (ret_en) begin
              if (w_empty) begin
                r_err     <= 1'b1;
                r_state   <= ST_DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_pc    <= r_stack[w_pop_idx];
                r_depth <= r_depth - DEPTH_ONE;
              end
            end else if (call_en) begin
              if (w_full) begin
                r_err     <= 1'b1;
                r_state   <= ST_DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_pc    <= target;
                r_depth <= r_depth + DEPTH_ONE;
              end
            end else if (absjump_en) begin
              r_pc <= target;
            end else if (reljump_en) begin
              r_pc <= w_pc_rel;
            end else begin
              r_pc <= w_pc_inc;
            end
          end
        end
        ST_DONE: begin
          if (!req) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_pc    <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_pc      <= '0;
          r_depth   <= '0;
          r_err     <= 1'b0;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  // Return-address storage; written only on an accepted call.
  // NOTE: the stack array has no reset -- entries above the depth pointer are
  // never read, so clearing them would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign prog_ctr  = r_pc;
  assign running   = r_running;
  assign done      = r_done;
  assign stk_err   = r_err;
  assign stk_depth = r_depth;

endmodule
